// File: rtl/pipeline_stage_sequencer.sv
// pipeline_stage_sequencer
// Drives the fetch/decode/execute enables of the pipeline so that stages
// come up one at a time (FILL1 -> FILL2 -> RUN) and go down one at a time
// (DRAIN1 -> DRAIN2). It runs bounded or unbounded fetch bursts on request,
// freezes everything while stall is high, and parks the core in SLEEP after
// a run of quiet IDLE cycles.
module pipeline_stage_sequencer #(
   parameter int CNT_W        = 8,
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] burst_len,
   input  logic             stop,
   input  logic             stall,
   input  logic             work_avail,
   output logic             enable_fetch,
   output logic             enable_decode,
   output logic             enable_execute,
   output logic             busy,
   output logic             sleep,
   output logic             done,
   output logic [CNT_W-1:0] fetch_count
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SLEEP  = 3'd1,
      ST_FILL1  = 3'd2,
      ST_FILL2  = 3'd3,
      ST_RUN    = 3'd4,
      ST_DRAIN1 = 3'd5,
      ST_DRAIN2 = 3'd6
   } state_t;

   // Timer value seen in the last quiet IDLE cycle before dropping to SLEEP.
   localparam logic [15:0] TIMER_LAST = 16'(IDLE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [15:0]      idle_timer_q, idle_timer_d;
   logic             done_q, done_d;

   logic [2:0]       stage_bits;   // {F, D, E} before stall masking
   logic [2:0]       stage_en;     // {F, D, E} after stall masking
   logic [CNT_W-1:0] fetch_inc;
   logic             burst_end;
   logic             accept_start;

   // Decode the unmasked per-stage enables from the current state.
   always_comb begin
      stage_bits = 3'b000;
      case (state_q)
         ST_FILL1:  stage_bits = 3'b100;
         ST_FILL2:  stage_bits = 3'b110;
         ST_RUN:    stage_bits = 3'b111;
         ST_DRAIN1: stage_bits = 3'b011;
         ST_DRAIN2: stage_bits = 3'b001;
         default:   stage_bits = 3'b000;
      endcase
   end

   // Stall masks every stage enable in the same cycle it is asserted.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_stage_mask
         assign stage_en[gi] = stage_bits[gi] & ~stall;
      end
   endgenerate

   assign enable_fetch   = stage_en[2];
   assign enable_decode  = stage_en[1];
   assign enable_execute = stage_en[0];
   assign busy           = (state_q != ST_IDLE) && (state_q != ST_SLEEP);
   assign sleep          = (state_q == ST_SLEEP);
   assign done           = done_q;
   assign fetch_count    = fetch_count_q;

   // Burst terminates when the fetch issued this cycle is the last one of a
   // bounded burst; a zero length means the burst only ends on stop.
   assign fetch_inc    = fetch_count_q + CNT_ONE;
   assign burst_end    = (len_q != '0) && (fetch_inc == len_q);
   assign accept_start = start && ((state_q == ST_IDLE) || (state_q == ST_SLEEP));

   // Next-state logic: everything holds while stalled; done is a single pulse.
   always_comb begin
      state_d       = state_q;
      fetch_count_d = fetch_count_q;
      len_d         = len_q;
      idle_timer_d  = idle_timer_q;
      done_d        = 1'b0;

      if (!stall) begin
         case (state_q)
            ST_IDLE: begin
               if (accept_start) begin
                  state_d       = ST_FILL1;
                  len_d         = burst_len;
                  fetch_count_d = '0;
                  idle_timer_d  = '0;
               end else if (work_avail) begin
                  idle_timer_d = '0;
               end else if (idle_timer_q == TIMER_LAST) begin
                  state_d      = ST_SLEEP;
                  idle_timer_d = '0;
               end else begin
                  idle_timer_d = idle_timer_q + 16'd1;
               end
            end

            ST_SLEEP: begin
               if (accept_start) begin
                  state_d       = ST_FILL1;
                  len_d         = burst_len;
                  fetch_count_d = '0;
                  idle_timer_d  = '0;
               end else if (work_avail) begin
                  state_d      = ST_IDLE;
                  idle_timer_d = '0;
               end
            end

            ST_FILL1, ST_FILL2, ST_RUN: begin
               // A fetch goes out in every unstalled fill/run cycle.
               fetch_count_d = fetch_inc;
               if (stop || burst_end) begin
                  state_d = ST_DRAIN1;
               end else if (state_q == ST_FILL1) begin
                  state_d = ST_FILL2;
               end else begin
                  state_d = ST_RUN;
               end
            end

            ST_DRAIN1: begin
               state_d = ST_DRAIN2;
            end

            ST_DRAIN2: begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         fetch_count_q <= '0;
         len_q         <= '0;
         idle_timer_q  <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_count_q <= fetch_count_d;
         len_q         <= len_d;
         idle_timer_q  <= idle_timer_d;
         done_q        <= done_d;
      end
   end

endmodule

// File: tb/tb_pipeline_stage_sequencer.sv
// tb_pipeline_stage_sequencer
// Directed bench: each burst is a short table of expected
// {F, D, E, busy, sleep, done} vectors, one per cycle, written by hand.
// Inputs change 1 time unit after the rising edge; outputs are checked
// on the falling edge.
module tb_pipeline_stage_sequencer;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [CNT_W-1:0] burst_len;
   logic             stop;
   logic             stall;
   logic             work_avail;
   logic             enable_fetch;
   logic             enable_decode;
   logic             enable_execute;
   logic             busy;
   logic             sleep;
   logic             done;
   logic [CNT_W-1:0] fetch_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [5:0] exp_v [0:11];

   pipeline_stage_sequencer #(
      .CNT_W       (CNT_W),
      .IDLE_TIMEOUT(16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .burst_len     (burst_len),
      .stop          (stop),
      .stall         (stall),
      .work_avail    (work_avail),
      .enable_fetch  (enable_fetch),
      .enable_decode (enable_decode),
      .enable_execute(enable_execute),
      .busy          (busy),
      .sleep         (sleep),
      .done          (done),
      .fetch_count   (fetch_count)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check, reports any mismatch.
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Wait for the falling edge, then compare {F,D,E,busy,sleep,done}.
   task automatic check_outs(input string tag, input logic [5:0] exp);
      @(negedge clk);
      check_val(tag,
                {26'd0, enable_fetch, enable_decode, enable_execute, busy, sleep, done},
                {26'd0, exp});
   endtask

   // Start a burst in cycle 0, then check exp_v[c] for cycles 0..ncyc.
   task automatic run_burst(input string name, input logic [CNT_W-1:0] len, input int ncyc,
                            input int stop_from, input int stop_to,
                            input int stall_from, input int stall_to, input int start2_c);
      next_cycle();
      start     = 1'b1;
      burst_len = len;
      stop      = 1'b0;
      stall     = 1'b0;
      check_outs($sformatf("%s c0", name), exp_v[0]);
      for (int c = 1; c <= ncyc; c++) begin
         next_cycle();
         start     = (c == start2_c);
         burst_len = (c == start2_c) ? CNT_W'(1) : len;
         stop      = (c >= stop_from) && (c <= stop_to);
         stall     = (c >= stall_from) && (c <= stall_to);
         check_outs($sformatf("%s c%0d", name, c), exp_v[c]);
      end
      start = 1'b0;
      stop  = 1'b0;
      stall = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b0;
      start      = 1'b0;
      burst_len  = '0;
      stop       = 1'b0;
      stall      = 1'b0;
      work_avail = 1'b0;

      // Reset held low for two edges.
      next_cycle();
      next_cycle();
      check_outs("reset outs", 6'b000000);
      check_val("reset fetch_count", 32'(fetch_count), 32'd0);
      reset = 1'b1;
      $display("reset released");

      // Quiet IDLE: SLEEP only after the 16th quiet edge.
      for (int i = 1; i <= 16; i++) begin
         next_cycle();
         check_outs($sformatf("quiet %0d", i), (i == 16) ? 6'b000010 : 6'b000000);
      end
      $display("entered sleep after 16 quiet cycles");

      // work_avail pulse wakes to IDLE one cycle later.
      next_cycle();
      work_avail = 1'b1;
      check_outs("wake c0", 6'b000010);
      next_cycle();
      work_avail = 1'b0;
      check_outs("wake c1", 6'b000000);
      for (int i = 1; i <= 16; i++) begin
         next_cycle();
         if (i >= 15) check_outs($sformatf("resleep %0d", i), (i == 16) ? 6'b000010 : 6'b000000);
      end
      $display("work_avail wake and return to sleep");

      // Length-4 burst started from SLEEP; a second start in RUN is ignored.
      exp_v = '{6'b000010, 6'b100100, 6'b110100, 6'b111100, 6'b111100, 6'b011100,
                6'b001100, 6'b000001, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
      run_burst("b4", CNT_W'(4), 7, 0, -1, 0, -1, 3);
      check_val("b4 fetch_count", 32'(fetch_count), 32'd4);
      $display("burst len=4 from sleep, fetch_count=%0d", fetch_count);

      // Length-1 burst: FILL1 straight to drain.
      exp_v = '{6'b000000, 6'b100100, 6'b011100, 6'b001100, 6'b000001, 6'b000000,
                6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
      run_burst("b1", CNT_W'(1), 4, 0, -1, 0, -1, -1);
      check_val("b1 fetch_count", 32'(fetch_count), 32'd1);
      $display("burst len=1, fetch_count=%0d", fetch_count);

      // Unbounded burst stopped in cycle 6.
      exp_v = '{6'b000000, 6'b100100, 6'b110100, 6'b111100, 6'b111100, 6'b111100,
                6'b111100, 6'b011100, 6'b001100, 6'b000001, 6'b000000, 6'b000000};
      run_burst("u6", CNT_W'(0), 9, 6, 6, 0, -1, -1);
      check_val("u6 fetch_count", 32'(fetch_count), 32'd6);
      $display("unbounded burst stop@6, fetch_count=%0d", fetch_count);

      // Same, with stall in cycles 3-4: everything shifts by two.
      exp_v = '{6'b000000, 6'b100100, 6'b110100, 6'b000100, 6'b000100, 6'b111100,
                6'b111100, 6'b111100, 6'b111100, 6'b011100, 6'b001100, 6'b000001};
      run_burst("st", CNT_W'(0), 11, 8, 8, 3, 4, -1);
      check_val("st fetch_count", 32'(fetch_count), 32'd6);
      $display("unbounded burst with 2-cycle stall, fetch_count=%0d", fetch_count);

      // Stop coincides with completion of a length-3 burst and stays high in drain.
      exp_v = '{6'b000000, 6'b100100, 6'b110100, 6'b111100, 6'b011100, 6'b001100,
                6'b000001, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
      run_burst("sc", CNT_W'(3), 6, 3, 6, 0, -1, -1);
      check_val("sc fetch_count", 32'(fetch_count), 32'd3);
      $display("stop with completion, fetch_count=%0d", fetch_count);

      // Unbounded counter wraps without ending the burst.
      next_cycle();
      start     = 1'b1;
      burst_len = '0;
      for (int c = 1; c <= 260; c++) begin
         next_cycle();
         start = 1'b0;
         stop  = (c == 257);
         if (c == 257) begin
            check_outs("wrap c257", 6'b111100);
            check_val("wrap fc c257", 32'(fetch_count), 32'd0);
         end else if (c == 258) begin
            check_outs("wrap c258", 6'b011100);
            check_val("wrap fc c258", 32'(fetch_count), 32'd1);
         end else if (c == 260) begin
            check_outs("wrap c260", 6'b000001);
         end
      end
      stop = 1'b0;
      $display("unbounded wrap, fetch_count=%0d", fetch_count);

      // Reset asserted in RUN: enables drop next cycle, no drain, no done.
      next_cycle();
      start     = 1'b1;
      burst_len = '0;
      next_cycle();
      start = 1'b0;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      check_outs("rr c3", 6'b111100);
      next_cycle();
      reset = 1'b1;
      check_outs("rr c4", 6'b000000);
      check_val("rr fetch_count", 32'(fetch_count), 32'd0);
      next_cycle();
      check_outs("rr c5", 6'b000000);
      next_cycle();
      check_outs("rr c6", 6'b000000);
      $display("reset during run");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
